// File: rtl/bus_util_monitor.sv
// Bus utilisation / grant-event / hog / starvation monitor.
// Latency: window results appear on the edge after the last window cycle; flags set on the threshold edge.
// Backpressure: none; every input is sampled each cycle and all outputs are registered.
module bus_util_monitor #(
    parameter int WINDOW_LEN   = 100,
    parameter int HOLD_LIMIT   = 64,
    parameter int STARVE_LIMIT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [11:0] m_reqs,
    input  logic [11:0] m_grants,
    input  logic        bus_util,
    output logic [7:0]  util_count,
    output logic        util_valid,
    output logic [7:0]  grant_events,
    output logic        hog_alarm,
    output logic [3:0]  hog_mid,
    output logic [11:0] starve
);

    localparam logic [7:0] WIN_LAST   = 8'(WINDOW_LEN - 1);
    localparam logic [7:0] HOLD_MAX   = 8'(HOLD_LIMIT);
    localparam logic [7:0] HOLD_PRE   = 8'(HOLD_LIMIT - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [7:0] STARVE_PRE = 8'(STARVE_LIMIT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  busy_acc_q, busy_acc_d;
    logic [7:0]  grant_acc_q, grant_acc_d;
    logic [7:0]  hog_cnt_q, hog_cnt_d;
    logic [11:0] prev_grants_q, prev_grants_d;
    logic [7:0]  util_count_q, util_count_d;
    logic        util_valid_q, util_valid_d;
    logic [7:0]  grant_events_q, grant_events_d;
    logic        hog_alarm_q, hog_alarm_d;
    logic [3:0]  hog_mid_q, hog_mid_d;
    logic [11:0] starve_q, starve_d;
    logic [7:0]  sc_q [12];
    logic [7:0]  sc_d [12];

    logic        run;
    logic        boundary;
    logic [11:0] rise;
    logic [3:0]  rise_cnt;
    logic [8:0]  grant_sum;
    logic [7:0]  grant_sat;
    logic [3:0]  low_idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run      = (state_q == RUN);
        boundary = run && (wcnt_q == WIN_LAST);
        rise     = m_grants & ~prev_grants_q;

        rise_cnt = '0;
        for (int i = 0; i < 12; i++) begin
            rise_cnt = rise_cnt + {3'b000, rise[i]};
        end
        grant_sum = {1'b0, grant_acc_q} + {5'b00000, rise_cnt};
        grant_sat = grant_sum[8] ? 8'hFF : grant_sum[7:0];

        low_idx = 4'hF;
        for (int i = 11; i >= 0; i--) begin
            if (m_grants[i]) low_idx = 4'(i);
        end

        wcnt_d         = wcnt_q;
        busy_acc_d     = busy_acc_q;
        grant_acc_d    = grant_acc_q;
        hog_cnt_d      = hog_cnt_q;
        prev_grants_d  = m_grants;
        util_count_d   = util_count_q;
        util_valid_d   = 1'b0;
        grant_events_d = grant_events_q;
        hog_alarm_d    = hog_alarm_q;
        hog_mid_d      = hog_mid_q;
        starve_d       = starve_q;
        sc_d           = sc_q;

        if (run) begin
            wcnt_d      = boundary ? 8'd0 : wcnt_q + 8'd1;
            busy_acc_d  = busy_acc_q + {7'd0, bus_util};
            grant_acc_d = grant_sat;

            if (bus_util) begin
                if (hog_cnt_q != HOLD_MAX) hog_cnt_d = hog_cnt_q + 8'd1;
                if (hog_cnt_q >= HOLD_PRE) begin
                    hog_alarm_d = 1'b1;
                    // Keep the first offender until software clears the alarm.
                    if (!hog_alarm_q) hog_mid_d = low_idx;
                end
            end else begin
                hog_cnt_d = '0;
            end

            for (int i = 0; i < 12; i++) begin
                if (m_reqs[i] && !m_grants[i]) begin
                    if (sc_q[i] != STARVE_MAX) sc_d[i] = sc_q[i] + 8'd1;
                    if (sc_q[i] >= STARVE_PRE) starve_d[i] = 1'b1;
                end else begin
                    sc_d[i] = '0;
                end
            end

            // The last window cycle's own activity is folded into the result.
            if (boundary) begin
                util_count_d   = busy_acc_q + {7'd0, bus_util};
                grant_events_d = grant_sat;
                util_valid_d   = 1'b1;
                busy_acc_d     = '0;
                grant_acc_d    = '0;
            end
        end

        if (clr) begin
            wcnt_d         = '0;
            busy_acc_d     = '0;
            grant_acc_d    = '0;
            hog_cnt_d      = '0;
            util_count_d   = util_count_q;
            grant_events_d = grant_events_q;
            util_valid_d   = 1'b0;
            hog_alarm_d    = 1'b0;
            hog_mid_d      = 4'hF;
            starve_d       = '0;
            for (int i = 0; i < 12; i++) sc_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wcnt_q         <= '0;
            busy_acc_q     <= '0;
            grant_acc_q    <= '0;
            hog_cnt_q      <= '0;
            prev_grants_q  <= '0;
            util_count_q   <= '0;
            util_valid_q   <= 1'b0;
            grant_events_q <= '0;
            hog_alarm_q    <= 1'b0;
            hog_mid_q      <= 4'hF;
            starve_q       <= '0;
            for (int i = 0; i < 12; i++) sc_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            busy_acc_q     <= busy_acc_d;
            grant_acc_q    <= grant_acc_d;
            hog_cnt_q      <= hog_cnt_d;
            prev_grants_q  <= prev_grants_d;
            util_count_q   <= util_count_d;
            util_valid_q   <= util_valid_d;
            grant_events_q <= grant_events_d;
            hog_alarm_q    <= hog_alarm_d;
            hog_mid_q      <= hog_mid_d;
            starve_q       <= starve_d;
            sc_q           <= sc_d;
        end
    end

    assign util_count   = util_count_q;
    assign util_valid   = util_valid_q;
    assign grant_events = grant_events_q;
    assign hog_alarm    = hog_alarm_q;
    assign hog_mid      = hog_mid_q;
    assign starve       = starve_q;

endmodule

// File: tb/tb_bus_util_monitor.sv
// Directed bench for bus_util_monitor at default parameters (window 100, hog 64, starve 32).
module tb_bus_util_monitor;

    logic        clk = 1'b0;
    logic        rst, en, clr, bus_util;
    logic [11:0] m_reqs, m_grants;
    logic [7:0]  util_count, grant_events;
    logic        util_valid, hog_alarm;
    logic [3:0]  hog_mid;
    logic [11:0] starve;

    always #5 clk = ~clk;

    bus_util_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .m_reqs       (m_reqs),
        .m_grants     (m_grants),
        .bus_util     (bus_util),
        .util_count   (util_count),
        .util_valid   (util_valid),
        .grant_events (grant_events),
        .hog_alarm    (hog_alarm),
        .hog_mid      (hog_mid),
        .starve       (starve)
    );

    typedef struct {
        int          n_busy;
        int          n_single;
        logic [11:0] multi;
        int          exp_util;
        int          exp_ge;
    } win_vec_t;

    typedef struct {
        logic [11:0] grants;
        int          exp_mid;
    } hog_vec_t;

    win_vec_t wv [5];
    hog_vec_t hv [5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_util_count"}, int'(util_count), 0);
        chk({tag, "_util_valid"}, int'(util_valid), 0);
        chk({tag, "_grant_events"}, int'(grant_events), 0);
        chk({tag, "_hog_alarm"}, int'(hog_alarm), 0);
        chk({tag, "_hog_mid"}, int'(hog_mid), 15);
        chk({tag, "_starve"}, int'(starve), 0);
    endtask

    // One full window: busy for the first n_busy cycles, single-bit grant
    // pulses at cycles 10/20/30, an optional multi-bit rise at cycle 80.
    task automatic run_window(input int idx, input win_vec_t v);
        int vcnt;
        vcnt = 0;
        for (int c = 0; c < 100; c++) begin
            bus_util = (c < v.n_busy) ? 1'b1 : 1'b0;
            m_grants = '0;
            if ((c == 10 && v.n_single > 0) || (c == 20 && v.n_single > 1) ||
                (c == 30 && v.n_single > 2)) m_grants = 12'h020;
            if (c == 80) m_grants = v.multi;
            tick();
            if (util_valid) vcnt++;
        end
        chk($sformatf("win%0d_valid_at_end", idx), int'(util_valid), 1);
        chk($sformatf("win%0d_valid_pulses", idx), vcnt, 1);
        chk($sformatf("win%0d_util_count", idx), int'(util_count), v.exp_util);
        chk($sformatf("win%0d_grant_events", idx), int'(grant_events), v.exp_ge);
        m_grants = '0;
        bus_util = 1'b0;
    endtask

    initial begin
        int vcnt;
        int n;
        logic found;

        wv[0] = '{37, 3, 12'h014, 37, 5};
        wv[1] = '{0, 0, 12'h000, 0, 0};
        wv[2] = '{100, 1, 12'hFFF, 100, 13};
        wv[3] = '{99, 0, 12'h000, 99, 0};
        wv[4] = '{1, 2, 12'h000, 1, 2};

        hv[0] = '{12'h000, 15};
        hv[1] = '{12'hA00, 9};
        hv[2] = '{12'h001, 0};
        hv[3] = '{12'h800, 11};
        hv[4] = '{12'h004, 2};

        rst = 1'b1; en = 1'b0; clr = 1'b0;
        m_reqs = '0; m_grants = '0; bus_util = 1'b0;
        tick();
        tick();
        chk_reset("reset");

        // IDLE: nothing counts, no strobes.
        rst = 1'b0;
        bus_util = 1'b1;
        m_grants = 12'h004;
        vcnt = 0;
        repeat (120) begin
            tick();
            if (util_valid) vcnt++;
        end
        chk("idle_no_valid", vcnt, 0);
        chk("idle_no_hog", int'(hog_alarm), 0);
        bus_util = 1'b0;
        m_grants = '0;
        tick();

        en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) run_window(i, wv[i]);

        // clr on the boundary cycle: no strobe, results untouched.
        bus_util = 1'b1;
        repeat (99) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_boundary_no_valid", int'(util_valid), 0);
        chk("clr_keeps_util_count", int'(util_count), 1);
        chk("clr_keeps_grant_events", int'(grant_events), 2);

        // Pause mid-window, then resume; busy cycles while paused must not count.
        vcnt = 0;
        repeat (30) begin
            tick();
            if (util_valid) vcnt++;
        end
        en = 1'b0;
        tick();
        repeat (20) begin
            tick();
            if (util_valid) vcnt++;
        end
        en = 1'b1;
        bus_util = 1'b0;
        tick();
        repeat (69) begin
            tick();
            if (util_valid) vcnt++;
        end
        chk("resume_valid_at_end", int'(util_valid), 1);
        chk("resume_valid_pulses", vcnt, 1);
        chk("resume_util_count", int'(util_count), 31);

        // 50 rises of all 12 bits in one window saturate the grant accumulator.
        for (int c = 0; c < 100; c++) begin
            m_grants = (c % 2 == 1) ? 12'hFFF : 12'h000;
            tick();
        end
        m_grants = '0;
        chk("sat_util_count", int'(util_count), 0);
        chk("sat_grant_events", int'(grant_events), 255);

        for (int i = 0; i < 5; i++) begin
            bus_util = 1'b0;
            clr = 1'b1;
            tick();
            clr = 1'b0;
            m_grants = hv[i].grants;
            bus_util = 1'b1;
            repeat (63) tick();
            chk($sformatf("hog%0d_not_yet", i), int'(hog_alarm), 0);
            tick();
            chk($sformatf("hog%0d_alarm", i), int'(hog_alarm), 1);
            chk($sformatf("hog%0d_mid", i), int'(hog_mid), hv[i].exp_mid);
        end
        m_grants = 12'h001;
        repeat (3) tick();
        chk("hog_mid_no_recapture", int'(hog_mid), 2);
        bus_util = 1'b0;
        tick();
        chk("hog_sticky", int'(hog_alarm), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("hog_clr_alarm", int'(hog_alarm), 0);
        chk("hog_clr_mid", int'(hog_mid), 15);
        m_grants = '0;

        m_reqs = 12'h010;
        repeat (31) tick();
        chk("starve_not_yet", int'(starve), 0);
        tick();
        chk("starve_set", int'(starve), 12'h010);
        m_reqs = '0;
        tick();
        chk("starve_sticky", int'(starve), 12'h010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("starve_clr", int'(starve), 0);
        m_reqs = 12'h010;
        repeat (31) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("starve_clr_overrides_set", int'(starve), 0);
        repeat (19) tick();
        m_grants = 12'h010;
        tick();
        m_grants = '0;
        repeat (25) tick();
        chk("starve_grant_restarts", int'(starve), 0);
        m_reqs = '0;

        // Build up every flag, then reset at wcnt=50.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_reqs = 12'h010;
        bus_util = 1'b1;
        repeat (150) tick();
        chk("pre_rst_hog", int'(hog_alarm), 1);
        chk("pre_rst_starve", int'(starve), 12'h010);
        chk("pre_rst_util_count", int'(util_count), 100);
        rst = 1'b1;
        clr = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        clr = 1'b0;
        m_reqs = '0;
        tick();
        n = 0;
        found = 1'b0;
        while (n < 200 && !found) begin
            tick();
            n++;
            if (util_valid) found = 1'b1;
        end
        chk("post_rst_valid_seen", int'(found), 1);
        chk("post_rst_valid_delay", n, 100);
        chk("post_rst_util_count", int'(util_count), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
